vga_timing_gen: RTL and testbench

- Generates 640x480 @ 60 Hz VGA raster timing from the 25 MHz `vga_clk`.
- Drives `DrawX`, `DrawY` and `blank` to the sprite/ROM-based pixel renderers.
- Drives `hs`/`vs` to the VGA connector, delayed so sync stays aligned with the renderers' two-cycle ROM+output-register pixel path.
- Also provides frame/line strobes for game-state update logic (tank movement, projectiles).

---
 rtl/vga_timing_gen.sv | 107 ++++++++++
 tb/tb_vga_timing_gen.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480 @ 60 Hz VGA raster timing: pixel/line counters, blanking, delayed
// active-low syncs and frame/line strobes for game-state update logic.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       sync,
  output logic       frame_start,
  output logic       line_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] hc;
  logic [9:0] vc;
  logic       h_wrap;
  logic       v_wrap;
  logic       hs_raw;
  logic       vs_raw;

  assign h_wrap = (hc == H_LAST);
  assign v_wrap = (vc == V_LAST);

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (h_wrap) begin
      hc <= '0;
      vc <= v_wrap ? '0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

  // Strobes register the wrap condition, so they rise together with the
  // counter returning to zero; reset never produces one.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
    end
  end

  assign DrawX  = hc;
  assign DrawY  = vc;
  assign blank  = (hc < H_VIS_END) && (vc < V_VIS_END);
  assign hs_raw = !((hc >= HS_START) && (hc < HS_END));
  assign vs_raw = !((vc >= VS_START) && (vc < VS_END));
  assign sync   = 1'b0;

  // Sync delay matches the renderers' ROM + output-register pixel latency.
  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign hs = hs_raw;
      assign vs = vs_raw;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_pipe;
      logic [SYNC_DELAY-1:0] vs_pipe;

      always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
          hs_pipe <= '1;
          vs_pipe <= '1;
        end else begin
          hs_pipe[0] <= hs_raw;
          vs_pipe[0] <= vs_raw;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
          end
        end
      end

      assign hs = hs_pipe[SYNC_DELAY-1];
      assign vs = vs_pipe[SYNC_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: random run/reset segments, expected
// outputs computed from elapsed clocks since reset release.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       sync;
    logic       fs;
    logic       ls;
  } out_t;

  typedef struct packed {
    int hv; int hf; int hsw; int hb;
    int vv; int vf; int vsw; int vb;
    int d;
  } params_t;

  localparam int S_HV = 16, S_HF = 4, S_HS = 6, S_HB = 6;
  localparam int S_VV = 10, S_VF = 2, S_VS = 2, S_VB = 3;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;

  always #5 vga_clk = ~vga_clk;

  out_t act_a, act_b, act_c;
  out_t q_a[$], q_b[$], q_c[$];
  params_t p_a, p_b, p_c;

  int t = 0;
  int vectors = 0;
  int miscompares = 0;

  vga_timing_gen #(
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .SYNC_DELAY(2)
  ) u_small (
    .vga_clk(vga_clk), .reset(reset),
    .DrawX(act_a.x), .DrawY(act_a.y), .blank(act_a.blank),
    .hs(act_a.hs), .vs(act_a.vs), .sync(act_a.sync),
    .frame_start(act_a.fs), .line_start(act_a.ls)
  );

  vga_timing_gen #(
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .SYNC_DELAY(0)
  ) u_zero (
    .vga_clk(vga_clk), .reset(reset),
    .DrawX(act_b.x), .DrawY(act_b.y), .blank(act_b.blank),
    .hs(act_b.hs), .vs(act_b.vs), .sync(act_b.sync),
    .frame_start(act_b.fs), .line_start(act_b.ls)
  );

  vga_timing_gen u_full (
    .vga_clk(vga_clk), .reset(reset),
    .DrawX(act_c.x), .DrawY(act_c.y), .blank(act_c.blank),
    .hs(act_c.hs), .vs(act_c.vs), .sync(act_c.sync),
    .frame_start(act_c.fs), .line_start(act_c.ls)
  );

  // Expected outputs after t counting edges since reset release.
  function automatic out_t model(input params_t p, input bit rst, input int tt);
    out_t e;
    int ht, vt, hc, vc, ts, hcs, vcs;
    ht = p.hv + p.hf + p.hsw + p.hb;
    vt = p.vv + p.vf + p.vsw + p.vb;
    e = '0;
    if (rst) begin
      e.blank = 1'b1;
      e.hs    = 1'b1;
      e.vs    = 1'b1;
      return e;
    end
    hc = tt % ht;
    vc = (tt / ht) % vt;
    e.x     = 10'(hc);
    e.y     = 10'(vc);
    e.blank = (hc < p.hv) && (vc < p.vv);
    ts = tt - p.d;
    if (ts < 0) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
    end else begin
      hcs  = ts % ht;
      vcs  = (ts / ht) % vt;
      e.hs = !((hcs >= p.hv + p.hf) && (hcs < p.hv + p.hf + p.hsw));
      e.vs = !((vcs >= p.vv + p.vf) && (vcs < p.vv + p.vf + p.vsw));
    end
    e.sync = 1'b0;
    e.ls   = (tt > 0) && (hc == 0);
    e.fs   = (tt > 0) && (tt % (ht * vt) == 0);
    return e;
  endfunction

  // Each cycle: advance elapsed count on a clean edge, then (re)drive reset
  // between edges and queue what every instance should show this cycle.
  task automatic applyStimulus(input bit rst_val, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge vga_clk);
      if (!reset) t++;
      #2;
      reset = rst_val;
      if (rst_val) t = 0;
      q_a.push_back(model(p_a, rst_val, t));
      q_b.push_back(model(p_b, rst_val, t));
      q_c.push_back(model(p_c, rst_val, t));
    end
  endtask

  task automatic checkOutput(input string name, input out_t act, input out_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got x=%0d y=%0d blank=%b hs=%b vs=%b sync=%b fs=%b ls=%b, want x=%0d y=%0d blank=%b hs=%b vs=%b sync=%b fs=%b ls=%b",
               name, $time, act.x, act.y, act.blank, act.hs, act.vs, act.sync, act.fs, act.ls,
               exp.x, exp.y, exp.blank, exp.hs, exp.vs, exp.sync, exp.fs, exp.ls);
    end
  endtask

  // Monitor: outputs are presented every cycle, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge vga_clk);
      if (q_a.size() > 0) checkOutput("small_d2", act_a, q_a.pop_front());
      if (q_b.size() > 0) checkOutput("small_d0", act_b, q_b.pop_front());
      if (q_c.size() > 0) checkOutput("full_d2", act_c, q_c.pop_front());
    end
  end

  initial begin
    p_a = '{hv:S_HV, hf:S_HF, hsw:S_HS, hb:S_HB, vv:S_VV, vf:S_VF, vsw:S_VS, vb:S_VB, d:2};
    p_b = '{hv:S_HV, hf:S_HF, hsw:S_HS, hb:S_HB, vv:S_VV, vf:S_VF, vsw:S_VS, vb:S_VB, d:0};
    p_c = '{hv:640, hf:16, hsw:96, hb:48, vv:480, vf:10, vsw:2, vb:33, d:2};
    $display("[TB] start");
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 3000);
    for (int s = 0; s < 10; s++) begin
      applyStimulus(1'b1, $urandom_range(1, 3));
      applyStimulus(1'b0, $urandom_range(20, 1200));
    end
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 900);
    @(negedge vga_clk);
    #1;
    vectors++;
    if (q_a.size() + q_b.size() + q_c.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expected entries left, want 0",
               q_a.size() + q_b.size() + q_c.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
